muldiv_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS datapath. It performs MULT, MULTU, DIV and DIVU at a parametrised width. The execute stage issues an operation with a one-cycle start pulse. The unit raises busy so the hazard unit can stall any mfhi/mflo/mthi/mtlo or new muldiv until done.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_unit_cond_neg.sv | 12 +
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_e;

    // op[1] equal to this selects a multiply; op[0] equal to the other selects signed
    localparam logic OP_MULT_BIT   = 1'b0;
    localparam logic OP_SIGNED_BIT = 1'b0;

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module cond_neg #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one radix-2 step per cycle.
// Optional MULDIV_EARLY_TERM_EN: multiplies stop once remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_e      state, state_nx;
    muldiv_op_e         op_q;
    logic [2*WIDTH-1:0] acc, acc_nx, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r;
    logic               is_div, last, sgn_in;
    logic [WIDTH-1:0]   mag_a, mag_b, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     top, diff;

    assign sgn_in = (op[0] == OP_SIGNED_BIT);
    assign is_div = (op_q[1] != OP_MULT_BIT);

    cond_neg #(.W(WIDTH)) u_mag_a (
        .neg (sgn_in & srca[WIDTH-1]),
        .a   (srca),
        .y   (mag_a)
    );

    cond_neg #(.W(WIDTH)) u_mag_b (
        .neg (sgn_in & srcb[WIDTH-1]),
        .a   (srcb),
        .y   (mag_b)
    );

    cond_neg #(.W(2*WIDTH)) u_fix_p (
        .neg (neg_q),
        .a   (acc),
        .y   (prod)
    );

    cond_neg #(.W(WIDTH)) u_fix_q (
        .neg (neg_q),
        .a   (acc[WIDTH-1:0]),
        .y   (quot)
    );

    cond_neg #(.W(WIDTH)) u_fix_r (
        .neg (neg_r),
        .a   (acc[2*WIDTH-1:WIDTH]),
        .y   (rem)
    );

    // Divide: acc = {partial remainder, dividend/quotient shift register}
    always_comb begin
        top    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = top - {1'b0, mcand[WIDTH-1:0]};
        acc_nx = acc;
        if (is_div) begin
            if (!diff[WIDTH])
                acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nx = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (mplier[0]) begin
            acc_nx = acc + mcand;
        end
    end

    always_comb begin
        last = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div && mplier[WIDTH-1:1] == '0)
            last = 1'b1;
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && !cancel) state_nx = RUN;
            RUN: begin
                if (cancel)    state_nx = IDLE;
                else if (last) state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state == FIX) && !cancel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_MULT;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        op_q   <= muldiv_op_e'(op);
                        cnt    <= '0;
                        neg_q  <= sgn_in & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r  <= sgn_in & srca[WIDTH-1];
                        mplier <= mag_b;
                        if (op[1] == OP_MULT_BIT) begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            mcand <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_nx;
                    if (!is_div) begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A FIX result overrides any mt write accepted earlier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX && !cancel) begin
            if (is_div) begin
                hi <= rem;
                lo <= quot;
            end else begin
                {hi, lo} <= prod;
            end
        end else if (!busy) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard and immediate assertions.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (!o[0] && b[31]) ? (~b + 32'd1) : b;
        k = 1;
        for (int i = 0; i < 32; i++)
            if (m[i]) k = i + 1;
        exp_lat = (o[1] || !EARLY) ? 33 : k + 1;
    endfunction

    // Starts at a negedge; returns at the negedge right after the sampling edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        if (push) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        srca  = $urandom;
        srcb  = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n;
        int nb;
        logic [63:0] e;
        n  = 0;
        nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy_cycles"}, 64'(nb), 64'(lat));
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, " scoreboard"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " hilo"}, {hi, lo}, e);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        issue(o, a, b, exp, 1'b1);
        wait_done(tag, exp_lat(o, b));
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk({tag, " no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] rexp;
        longint      sp;
        int          sq, sr;

        reset  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        srca   = '0;
        srcb   = '0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run("mult_m1x7", 2'b00, 32'hFFFFFFFF, 32'h00000007, 64'hFFFFFFFF_FFFFFFF9);

        // Each start below lands in the done cycle of the previous operation
        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run("divu_7_2", 2'b11, 32'h00000007, 32'h00000002, 64'h00000001_00000003);
        run("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run("divu_by0", 2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF);
        run("div_neg_by0", 2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_00000001);
        run("div_pos_by0", 2'b10, 32'h00000009, 32'h00000000, 64'h00000009_FFFFFFFF);
        run("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run("multu_5x3", 2'b01, 32'h00000005, 32'h00000003, 64'h00000000_0000000F);
        run("mult_x0", 2'b00, 32'h12345678, 32'h00000000, 64'h0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(20, 31);
            if (ro[1] && rb == 0) rb = 32'd3;
            if (ro == 2'b10 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            case (ro)
                2'b00: begin
                    sp   = longint'($signed(ra)) * longint'($signed(rb));
                    rexp = 64'(sp);
                end
                2'b01: rexp = {32'd0, ra} * {32'd0, rb};
                2'b10: begin
                    sq   = $signed(ra) / $signed(rb);
                    sr   = $signed(ra) % $signed(rb);
                    rexp = {32'(sr), 32'(sq)};
                end
                default: rexp = {ra % rb, ra / rb};
            endcase
            run($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rexp);
        end

        // mt writes, then a cancelled multiply that must leave HI/LO alone
        hi_we = 1'b1;
        wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mt preload", {hi, lo}, {32'h11, 32'h22});
        issue(2'b01, 32'h0000FFFF, 32'hFFFF0000, 64'h0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            if (i == 4) begin
                hi_we = 1'b1;
                wdata = 32'h99;
            end else begin
                hi_we = 1'b0;
            end
            @(negedge clk);
        end
        hi_we  = 1'b0;
        chk("busy before cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        no_done("cancel", 40);
        chk("cancel hilo", {hi, lo}, {32'h11, 32'h22});

        // Asynchronous reset in the middle of a divide
        issue(2'b10, 32'h00001234, 32'h00000007, 64'h0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset hilo", {hi, lo}, 64'd0);
        chk("async reset busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        no_done("after reset", 40);

        run("post_reset_divu", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
